and_unit: RTL and testbench

//   Bitwise 2-input AND primitive for datapath glue logic.

---
 rtl/and_unit_pkg.sv | 8 +
 rtl/and_unit.sv | 43 ++++
 tb/tb_and_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/and_unit_pkg.sv
// Shared defaults for the and_unit datapath primitive.
// Kept small so glue blocks can pick the same widths.
package and_unit_pkg;

  localparam int unsigned AND_WIDTH_DEF = 1;
  localparam int unsigned AND_CNT_W_DEF = 8;

endpackage

// File: rtl/and_unit.sv
// Bitwise AND primitive with registered copies and a
// saturating all-ones event counter for debug visibility.
module and_unit
  import and_unit_pkg::*;
#(
  parameter int unsigned WIDTH = AND_WIDTH_DEF,
  parameter int unsigned CNT_W = AND_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_all_q,
  output logic             vld_q,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic y_all;

  assign y     = a & b;
  assign y_all = &y;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      y_all_q  <= 1'b0;
      vld_q    <= 1'b0;
      ones_cnt <= '0;
    end else begin
      y_q     <= y;
      y_all_q <= y_all;
      vld_q   <= 1'b1;
      // hold at max rather than wrap
      if (y_all && (ones_cnt != CNT_MAX))
        ones_cnt <= ones_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_and_unit.sv
// Directed and randomized checks of and_unit against a
// behavioural model, on a 1-bit and a 4-bit/2-bit-counter instance.
module tb_and_unit;

  logic       clk = 1'b0;
  logic       run = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [3:0] a4 = '0, b4 = '0;

  logic [0:0] y1, yq1;
  logic       all1, vld1;
  logic [7:0] cnt1;
  logic [3:0] y4, yq4;
  logic       all4, vld4;
  logic [1:0] cnt4;

  int pass_cnt = 0;
  int total = 0;

  int m_yq1, m_all1, m_vld1, m_cnt1;
  int m_yq4, m_all4, m_vld4, m_cnt4;

  and_unit #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .y(y1), .y_q(yq1), .y_all_q(all1),
    .vld_q(vld1), .ones_cnt(cnt1)
  );

  and_unit #(.WIDTH(4), .CNT_W(2)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .y(y4), .y_q(yq4), .y_all_q(all4),
    .vld_q(vld4), .ones_cnt(cnt4)
  );

  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic step(string tag);
    int p1, p4;
    p1 = int'(a1 & b1);
    p4 = int'(a4 & b4);
    if (rst) begin
      m_yq1 = 0; m_all1 = 0; m_vld1 = 0; m_cnt1 = 0;
      m_yq4 = 0; m_all4 = 0; m_vld4 = 0; m_cnt4 = 0;
    end else begin
      m_yq1  = p1;
      m_all1 = (p1 == 1) ? 1 : 0;
      m_vld1 = 1;
      if (m_all1 == 1 && m_cnt1 < 255) m_cnt1++;
      m_yq4  = p4;
      m_all4 = (p4 == 15) ? 1 : 0;
      m_vld4 = 1;
      if (m_all4 == 1 && m_cnt4 < 3) m_cnt4++;
    end
    @(posedge clk);
    #1;
    check({tag, "/y1"}, 32'(y1), 32'(a1 & b1));
    check({tag, "/y4"}, 32'(y4), 32'(a4 & b4));
    check({tag, "/yq1"}, 32'(yq1), 32'(m_yq1));
    check({tag, "/all1"}, 32'(all1), 32'(m_all1));
    check({tag, "/vld1"}, 32'(vld1), 32'(m_vld1));
    check({tag, "/cnt1"}, 32'(cnt1), 32'(m_cnt1));
    check({tag, "/yq4"}, 32'(yq4), 32'(m_yq4));
    check({tag, "/all4"}, 32'(all4), 32'(m_all4));
    check({tag, "/vld4"}, 32'(vld4), 32'(m_vld4));
    check({tag, "/cnt4"}, 32'(cnt4), 32'(m_cnt4));
  endtask

  initial begin
    // combinational truth table with clock stopped
    a1 = 1'b1; b1 = 1'b1; #1;
    check("comb11", 32'(y1), 32'd1);
    a1 = 1'b0; b1 = 1'b1; #1;
    check("comb01", 32'(y1), 32'd0);
    a1 = 1'b1; b1 = 1'b0; #1;
    check("comb10", 32'(y1), 32'd0);
    a1 = 1'b0; b1 = 1'b0; #1;
    check("comb00", 32'(y1), 32'd0);
    a4 = 4'b1100; b4 = 4'b1010; #1;
    check("comb4", 32'(y4), 32'b1000);

    // reset for two edges, then all-ones
    run = 1'b1;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step("sat");
    check("sat_cnt4", 32'(cnt4), 32'd3);
    check("run_cnt1", 32'(cnt1), 32'd6);

    // randomized traffic, biased toward all-ones
    for (int i = 0; i < 60; i++) begin
      rst = ($urandom_range(0, 9) == 0);
      a1  = ($urandom_range(0, 3) != 0);
      b1  = ($urandom_range(0, 3) != 0);
      a4  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      b4  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      step("rnd");
    end

    // mid-run reset with all-ones input: reset wins
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    step("pre");
    rst = 1'b1;
    step("midrst");
    check("midrst_y1", 32'(y1), 32'd1);
    check("midrst_cnt1", 32'(cnt1), 32'd0);
    rst = 1'b0;

    // long all-ones run saturates the 8-bit counter
    for (int i = 0; i < 260; i++) step("long");
    check("sat_cnt1", 32'(cnt1), 32'd255);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
